// File: rtl/dac_sched_pkg.sv
// Shared defaults and FSM state encodings for the DAC sample scheduler.
package dac_sched_pkg;

  localparam int DATA_W_DEF   = 12;
  localparam int TICK_DIV_DEF = 2500;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; pointers carry one extra bit so full and empty
// can be told apart without a separate occupancy counter.
module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int AW    = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2**AW];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  // Storage is not reset; resetting the pointers is enough to flush it.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Round-robin intake of two sample producers into a FIFO, and one serializer
// transfer per sample-rate tick with sample-hold on underrun.
module dac_sample_scheduler
  import dac_sched_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int FIFO_AW  = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Enable,
  input  logic              Req_A,
  input  logic [DATA_W-1:0] Data_A,
  output logic              Gnt_A,
  input  logic              Req_B,
  input  logic [DATA_W-1:0] Data_B,
  output logic              Gnt_B,
  output logic [DATA_W-1:0] Tx_Data,
  output logic              Tx_Start,
  input  logic              Tx_Done,
  output logic              Underrun,
  output logic              Overflow,
  output logic              Late,
  input  logic              Clr_Flags
);

  localparam int                CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0]  tick_cnt_reg;
  logic              tick;
  logic              prefer_b_reg;
  logic              can_grant;
  logic              gnt_a;
  logic              gnt_b;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;
  logic [DATA_W-1:0] tx_data_reg;
  logic              underrun_reg;
  logic              overflow_reg;
  logic              late_reg;
  state_t            state_reg;
  state_t            state_next;
  logic              pop;
  logic              tx_start;
  logic              underrun_evt;
  logic              late_evt;
  logic              overflow_evt;

  // Tick counter: held at zero while disabled so re-enable restarts a full period.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tick_cnt_reg <= '0;
    end else if (!Enable || tick_cnt_reg == TICK_LAST) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
    end
  end

  assign tick = Enable && (tick_cnt_reg == TICK_LAST);

  // Arbiter: fullness is registered, so a same-cycle pop never opens a slot.
  assign can_grant    = Rst && Enable && !fifo_full;
  assign gnt_a        = can_grant && Req_A && (!Req_B || !prefer_b_reg);
  assign gnt_b        = can_grant && Req_B && (!Req_A || prefer_b_reg);
  assign overflow_evt = fifo_full && (Req_A || Req_B);
  assign Gnt_A        = gnt_a;
  assign Gnt_B        = gnt_b;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      prefer_b_reg <= 1'b0;
    end else if (gnt_a) begin
      prefer_b_reg <= 1'b1;
    end else if (gnt_b) begin
      prefer_b_reg <= 1'b0;
    end
  end

  sample_fifo #(
    .WIDTH (DATA_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .Clk     (Clk),
    .Rst     (Rst),
    .push    (gnt_a || gnt_b),
    .wr_data (gnt_b ? Data_B : Data_A),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pop          = 1'b0;
    tx_start     = 1'b0;
    underrun_evt = 1'b0;
    late_evt     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (tick) begin
          state_next   = ST_LOAD;
          pop          = !fifo_empty;
          underrun_evt = fifo_empty;
        end
      end
      ST_LOAD: begin
        tx_start   = 1'b1;
        late_evt   = tick;
        state_next = ST_BUSY;
      end
      ST_BUSY: begin
        late_evt = tick;
        if (Tx_Done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Tx_Data only changes on a successful pop, giving sample-hold on underrun.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tx_data_reg <= '0;
    end else if (pop) begin
      tx_data_reg <= fifo_rd_data;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      underrun_reg <= 1'b0;
      overflow_reg <= 1'b0;
      late_reg     <= 1'b0;
    end else begin
      underrun_reg <= (underrun_reg && !Clr_Flags) || underrun_evt;
      overflow_reg <= (overflow_reg && !Clr_Flags) || overflow_evt;
      late_reg     <= (late_reg && !Clr_Flags) || late_evt;
    end
  end

  assign Tx_Data  = tx_data_reg;
  assign Tx_Start = tx_start;
  assign Underrun = underrun_reg;
  assign Overflow = overflow_reg;
  assign Late     = late_reg;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Directed scenario bench for dac_sample_scheduler with a serializer model.
module tb_dac_sample_scheduler;

  localparam int DW = 12;
  localparam int TD = 32;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Enable;
  logic          Req_A;
  logic [DW-1:0] Data_A;
  logic          Gnt_A;
  logic          Req_B;
  logic [DW-1:0] Data_B;
  logic          Gnt_B;
  logic [DW-1:0] Tx_Data;
  logic          Tx_Start;
  logic          Tx_Done = 1'b0;
  logic          Underrun;
  logic          Overflow;
  logic          Late;
  logic          Clr_Flags;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_delay = 20;
  int ser_cnt = 0;
  int start_cyc[$];
  logic [DW-1:0] start_data[$];

  dac_sample_scheduler #(
    .DATA_W   (DW),
    .TICK_DIV (TD),
    .FIFO_AW  (2)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Enable    (Enable),
    .Req_A     (Req_A),
    .Data_A    (Data_A),
    .Gnt_A     (Gnt_A),
    .Req_B     (Req_B),
    .Data_B    (Data_B),
    .Gnt_B     (Gnt_B),
    .Tx_Data   (Tx_Data),
    .Tx_Start  (Tx_Start),
    .Tx_Done   (Tx_Done),
    .Underrun  (Underrun),
    .Overflow  (Overflow),
    .Late      (Late),
    .Clr_Flags (Clr_Flags)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Serializer model and transfer log: Tx_Done pulses done_delay cycles after Tx_Start.
  always @(negedge Clk) begin
    if (Rst !== 1'b1) begin
      ser_cnt = 0;
      Tx_Done = 1'b0;
    end else begin
      Tx_Done = 1'b0;
      if (Tx_Start === 1'b1) begin
        start_cyc.push_back(cyc);
        start_data.push_back(Tx_Data);
        ser_cnt = done_delay;
        $display("tx_start cyc=%0d data=%h", cyc, Tx_Data);
      end else if (ser_cnt > 0) begin
        ser_cnt--;
        if (ser_cnt == 0) Tx_Done = 1'b1;
      end
    end
  end

  task automatic step;
    @(negedge Clk);
    #1;
  endtask

  task automatic do_reset;
    Rst = 1'b0; Enable = 1'b0; Req_A = 1'b0; Req_B = 1'b0;
    Data_A = '0; Data_B = '0; Clr_Flags = 1'b0;
    repeat (3) step;
    Rst = 1'b1;
    start_cyc.delete();
    start_data.delete();
  endtask

  task automatic wait_starts(input int n, input int bound);
    for (int i = 0; i < bound && start_cyc.size() < n; i++) step;
  endtask

  task automatic push_a(input logic [DW-1:0] d, output int gc);
    gc = -1;
    Req_A = 1'b1;
    Data_A = d;
    for (int i = 0; i < 100 && gc < 0; i++) begin
      #1;
      if (Gnt_A === 1'b1) gc = cyc;
      step;
    end
    Req_A = 1'b0;
  endtask

  task automatic test_reset;
    Rst = 1'b0; Enable = 1'b1; Req_A = 1'b1; Req_B = 1'b1;
    Data_A = 12'hFFF; Data_B = 12'hFFF; Clr_Flags = 1'b0;
    step; step;
    checks++;
    if ({Gnt_A, Gnt_B, Tx_Start, Underrun, Overflow, Late} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=000000", {Gnt_A, Gnt_B, Tx_Start, Underrun, Overflow, Late});
    end
    checks++;
    if (Tx_Data !== 12'h000) begin
      errors++;
      $display("FAIL reset_txdata got=%h exp=000", Tx_Data);
    end
  endtask

  task automatic test_single_producer;
    int cyc_en, g0, g1, g2;
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 12'h123; exp_d[1] = 12'h456; exp_d[2] = 12'h789;
    do_reset;
    done_delay = 20;
    Enable = 1'b1;
    cyc_en = cyc;
    push_a(12'h123, g0);
    push_a(12'h456, g1);
    push_a(12'h789, g2);
    checks++;
    if (g0 != cyc_en || g1 != cyc_en + 1 || g2 != cyc_en + 2) begin
      errors++;
      $display("FAIL single_grants got=%0d,%0d,%0d exp=%0d,%0d,%0d", g0, g1, g2, cyc_en, cyc_en + 1, cyc_en + 2);
    end
    wait_starts(3, 150);
    checks++;
    if (start_cyc.size() < 3) begin
      errors++;
      $display("FAIL single_timeout got=%0d starts exp=3", start_cyc.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (start_cyc[k] != cyc_en + TD * (k + 1) || start_data[k] !== exp_d[k]) begin
          errors++;
          $display("FAIL single_start%0d got=cyc%0d/%h exp=cyc%0d/%h", k, start_cyc[k], start_data[k], cyc_en + TD * (k + 1), exp_d[k]);
        end
      end
    end
    checks++;
    if ({Underrun, Overflow, Late} !== 3'b000) begin
      errors++;
      $display("FAIL single_flags got=%b exp=000", {Underrun, Overflow, Late});
    end
  endtask

  task automatic test_round_robin;
    logic [4:0] exp_a, exp_b;
    logic [DW-1:0] exp_d [4];
    exp_a = 5'b00101; exp_b = 5'b01010;
    exp_d[0] = 12'hAAA; exp_d[1] = 12'hBBB; exp_d[2] = 12'hAAA; exp_d[3] = 12'hBBB;
    do_reset;
    Enable = 1'b1;
    Data_A = 12'hAAA; Data_B = 12'hBBB;
    Req_A = 1'b1; Req_B = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (Gnt_A !== exp_a[k] || Gnt_B !== exp_b[k]) begin
        errors++;
        $display("FAIL rr_grant%0d got=A%b/B%b exp=A%b/B%b", k, Gnt_A, Gnt_B, exp_a[k], exp_b[k]);
      end
      if (k == 4) begin
        checks++;
        if (Overflow !== 1'b0) begin
          errors++;
          $display("FAIL rr_overflow_early got=%b exp=0", Overflow);
        end
      end
      step;
    end
    checks++;
    if (Overflow !== 1'b1) begin
      errors++;
      $display("FAIL rr_overflow got=%b exp=1", Overflow);
    end
    wait_starts(4, 200);
    checks++;
    if (start_cyc.size() < 4) begin
      errors++;
      $display("FAIL rr_timeout got=%0d starts exp=4", start_cyc.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (start_data[k] !== exp_d[k]) begin
          errors++;
          $display("FAIL rr_data%0d got=%h exp=%h", k, start_data[k], exp_d[k]);
        end
      end
    end
    Req_A = 1'b0; Req_B = 1'b0;
  endtask

  task automatic test_underrun_hold;
    int cyc_en, g;
    do_reset;
    Enable = 1'b1;
    cyc_en = cyc;
    push_a(12'h5A5, g);
    wait_starts(2, 150);
    checks++;
    if (start_cyc.size() < 2) begin
      errors++;
      $display("FAIL underrun_timeout got=%0d starts exp=2", start_cyc.size());
    end else begin
      checks++;
      if (start_cyc[1] != cyc_en + 2 * TD || start_data[1] !== 12'h5A5 || start_data[0] !== 12'h5A5) begin
        errors++;
        $display("FAIL underrun_hold got=cyc%0d/%h exp=cyc%0d/5a5", start_cyc[1], start_data[1], cyc_en + 2 * TD);
      end
    end
    checks++;
    if (Underrun !== 1'b1 || Late !== 1'b0) begin
      errors++;
      $display("FAIL underrun_flag got=U%b/L%b exp=U1/L0", Underrun, Late);
    end
    Clr_Flags = 1'b1;
    step;
    Clr_Flags = 1'b0;
    checks++;
    if (Underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear got=%b exp=0", Underrun);
    end
    while (cyc < cyc_en + 3 * TD - 1) step;
    Clr_Flags = 1'b1;
    step;
    Clr_Flags = 1'b0;
    checks++;
    if (Underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_set_beats_clear got=%b exp=1", Underrun);
    end
  endtask

  task automatic test_late_tick;
    int cyc_en, g;
    do_reset;
    done_delay = 40;
    Enable = 1'b1;
    cyc_en = cyc;
    push_a(12'h111, g);
    push_a(12'h222, g);
    push_a(12'h333, g);
    wait_starts(1, 100);
    checks++;
    if (Late !== 1'b0) begin
      errors++;
      $display("FAIL late_early got=%b exp=0", Late);
    end
    wait_starts(2, 150);
    checks++;
    if (start_cyc.size() < 2) begin
      errors++;
      $display("FAIL late_timeout got=%0d starts exp=2", start_cyc.size());
    end else begin
      checks++;
      if (start_cyc[1] != cyc_en + 3 * TD || start_data[1] !== 12'h222) begin
        errors++;
        $display("FAIL late_next_start got=cyc%0d/%h exp=cyc%0d/222", start_cyc[1], start_data[1], cyc_en + 3 * TD);
      end
    end
    checks++;
    if (Late !== 1'b1 || Underrun !== 1'b0) begin
      errors++;
      $display("FAIL late_flag got=L%b/U%b exp=L1/U0", Late, Underrun);
    end
    done_delay = 20;
  endtask

  task automatic test_reset_mid_busy;
    int g, cyc_r;
    do_reset;
    Enable = 1'b1;
    push_a(12'h100, g);
    push_a(12'h200, g);
    push_a(12'h300, g);
    push_a(12'h400, g);
    wait_starts(1, 100);
    checks++;
    if (start_cyc.size() < 1 || start_data[0] !== 12'h100) begin
      errors++;
      $display("FAIL rstbusy_first got=%0d starts exp=1 with data 100", start_cyc.size());
    end
    repeat (5) step;
    Rst = 1'b0;
    Req_A = 1'b1;
    Data_A = 12'h999;
    #1;
    checks++;
    if ({Gnt_A, Gnt_B, Tx_Start, Underrun, Overflow, Late} !== 6'b0 || Tx_Data !== 12'h000) begin
      errors++;
      $display("FAIL rstbusy_outputs got=%b/%h exp=000000/000", {Gnt_A, Gnt_B, Tx_Start, Underrun, Overflow, Late}, Tx_Data);
    end
    step;
    Req_A = 1'b0;
    Rst = 1'b1;
    cyc_r = cyc;
    start_cyc.delete();
    start_data.delete();
    wait_starts(1, 100);
    checks++;
    if (start_cyc.size() < 1) begin
      errors++;
      $display("FAIL rstbusy_timeout got=0 starts exp=1");
    end else begin
      checks++;
      if (start_cyc[0] != cyc_r + TD || start_data[0] !== 12'h000 || Underrun !== 1'b1) begin
        errors++;
        $display("FAIL rstbusy_after got=cyc%0d/%h/U%b exp=cyc%0d/000/U1", start_cyc[0], start_data[0], Underrun, cyc_r + TD);
      end
    end
  endtask

  task automatic test_enable_pause;
    int cyc_en, cyc_e2, g;
    do_reset;
    Enable = 1'b1;
    cyc_en = cyc;
    push_a(12'h777, g);
    while (cyc < cyc_en + TD - 6) step;
    Enable = 1'b0;
    repeat (3 * TD) step;
    checks++;
    if (start_cyc.size() != 0) begin
      errors++;
      $display("FAIL pause_no_start got=%0d starts exp=0", start_cyc.size());
    end
    Enable = 1'b1;
    cyc_e2 = cyc;
    wait_starts(1, 100);
    checks++;
    if (start_cyc.size() < 1) begin
      errors++;
      $display("FAIL pause_timeout got=0 starts exp=1");
    end else begin
      checks++;
      if (start_cyc[0] != cyc_e2 + TD || start_data[0] !== 12'h777 || Underrun !== 1'b0) begin
        errors++;
        $display("FAIL pause_resume got=cyc%0d/%h/U%b exp=cyc%0d/777/U0", start_cyc[0], start_data[0], Underrun, cyc_e2 + TD);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_single_producer;
    test_round_robin;
    test_underrun_hold;
    test_late_tick;
    test_reset_mid_busy;
    test_enable_pause;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
